// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers ROM output for decode, handles stall/jump/halt.
// Optional return-address stack for call/return is enabled by defining RETURN_STACK_EN.
module fetch_unit #(
  parameter int unsigned             ADDR_W    = 17,
  parameter int unsigned             INSTR_W   = 19,
  parameter logic [ADDR_W-1:0]       RESET_VEC = '0,
  parameter int unsigned             RS_DEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_instrAddr,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [ADDR_W-1:0]  i_target,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic               i_halt,
  input  logic               i_resume,
  output logic               o_halted,
  output logic               o_rs_err
);

  typedef enum logic {RUN, HALT} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  pc, pc_nx, opc, opc_nx;
  logic [INSTR_W-1:0] instr, instr_nx;
  logic               valid, valid_nx;

`ifdef RETURN_STACK_EN
  localparam int unsigned   PTR_W   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [PTR_W:0] RS_FULL = (PTR_W + 1)'(RS_DEPTH);

  logic [ADDR_W-1:0] rs_mem [RS_DEPTH];
  logic [PTR_W-1:0]  rs_ptr;
  logic [PTR_W:0]    rs_cnt;
  logic              rs_err;
  logic [ADDR_W-1:0] rs_top;
  logic              push, pop, rs_err_set;

  assign rs_top = rs_mem[rs_ptr - PTR_W'(1)];
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    opc_nx   = opc;
    instr_nx = instr;
    valid_nx = valid;
`ifdef RETURN_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
    rs_err_set = 1'b0;
`endif
    case (state)
      RUN: begin
        if (i_halt) begin
          state_nx = HALT;
          valid_nx = 1'b0;
        end else if (i_jump) begin
          pc_nx    = i_target;
          valid_nx = 1'b0;
        end else if (i_call) begin
          pc_nx    = i_target;
          valid_nx = 1'b0;
`ifdef RETURN_STACK_EN
          push     = 1'b1;
`endif
        end
`ifdef RETURN_STACK_EN
        else if (i_ret) begin
          valid_nx = 1'b0;
          if (rs_cnt == '0) begin
            rs_err_set = 1'b1;
            state_nx   = HALT;
          end else begin
            pc_nx = rs_top;
            pop   = 1'b1;
          end
        end
`endif
        else if (!i_stall) begin
          instr_nx = i_instr;
          opc_nx   = pc;
          valid_nx = 1'b1;
          pc_nx    = pc + ADDR_W'(1);
        end
      end
      HALT: begin
        valid_nx = 1'b0;
        if (i_resume && !i_halt) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      pc    <= RESET_VEC;
      opc   <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      opc   <= opc_nx;
      instr <= instr_nx;
      valid <= valid_nx;
    end
  end

`ifdef RETURN_STACK_EN
  // Circular buffer: a push when full overwrites the oldest entry while count saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs_ptr <= '0;
      rs_cnt <= '0;
      rs_err <= 1'b0;
    end else begin
      if (push) begin
        rs_mem[rs_ptr] <= pc;
        rs_ptr         <= rs_ptr + PTR_W'(1);
        if (rs_cnt == RS_FULL) rs_err <= 1'b1;
        else                   rs_cnt <= rs_cnt + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rs_ptr <= rs_ptr - PTR_W'(1);
        rs_cnt <= rs_cnt - (PTR_W + 1)'(1);
      end
      if (rs_err_set) rs_err <= 1'b1;
    end
  end

  assign o_rs_err = rs_err;
`else
  logic unused;
  assign unused   = i_ret ^ (RS_DEPTH == 0);
  assign o_rs_err = 1'b0;
`endif

  assign o_instrAddr = pc;
  assign o_instr     = instr;
  assign o_valid     = valid;
  assign o_pc        = opc;
  assign o_halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations. Covers RETURN_STACK_EN when defined.
module tb_fetch_unit;
  localparam int AW    = 17;
  localparam int IW    = 19;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, stall, jump, call, ret, halt, resume;
  logic [AW-1:0] target;
  logic [AW-1:0] addr;
  logic [IW-1:0] rom_data, instr;
  logic          valid, halted, rs_err;
  logic [AW-1:0] pc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_VEC('0), .RS_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .o_instrAddr(addr), .i_instr(rom_data),
    .o_instr(instr), .o_valid(valid), .o_pc(pc), .i_stall(stall),
    .i_jump(jump), .i_target(target), .i_call(call), .i_ret(ret),
    .i_halt(halt), .i_resume(resume), .o_halted(halted), .o_rs_err(rs_err)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return IW'(a) + IW'('h100);
  endfunction

  assign rom_data = rom(addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: architectural state kept as plain values and a queue for the return stack.
  logic [AW-1:0] m_pc, m_opc;
  logic [IW-1:0] m_instr;
  bit            m_valid, m_halted, m_err;
  logic [AW-1:0] m_stack[$];
`ifdef RETURN_STACK_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_opc = '0; m_instr = '0; m_valid = 0; m_halted = 0; m_err = 0;
      m_stack.delete();
    end else if (m_halted) begin
      m_valid = 0;
      if (resume && !halt) m_halted = 0;
    end else if (halt) begin
      m_halted = 1; m_valid = 0;
    end else if (jump || (call && !RS)) begin
      m_pc = target; m_valid = 0;
    end else if (call) begin
      if (m_stack.size() == DEPTH) begin
        void'(m_stack.pop_front());
        m_err = 1;
      end
      m_stack.push_back(m_pc);
      m_pc = target; m_valid = 0;
    end else if (ret && RS) begin
      m_valid = 0;
      if (m_stack.size() == 0) begin
        m_err = 1; m_halted = 1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (!stall) begin
      m_instr = rom(m_pc); m_opc = m_pc; m_valid = 1;
      m_pc = m_pc + AW'(1);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_addr",   32'(addr),   32'(m_pc));
      check("m_valid",  32'(valid),  32'(m_valid));
      check("m_halted", 32'(halted), 32'(m_halted));
      check("m_rs_err", 32'(rs_err), 32'(m_err));
      if (m_valid) begin
        check("m_instr", 32'(instr), 32'(m_instr));
        check("m_pc",    32'(pc),    32'(m_opc));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1; tick; rst = 0;
  endtask

  initial begin
    rst = 1; stall = 0; jump = 0; call = 0; ret = 0; halt = 0; resume = 0; target = '0;
    tick; tick;
    rst = 0;
    cmp_en = 1;

    check("rst_addr",   32'(addr),   0);
    check("rst_valid",  32'(valid),  0);
    check("rst_instr",  32'(instr),  0);
    check("rst_pc",     32'(pc),     0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err",    32'(rs_err), 0);

    tick; check("run1_addr", 32'(addr), 1); check("run1_instr", 32'(instr), 'h100); check("run1_pc", 32'(pc), 0);
    check("run1_valid", 32'(valid), 1);
    tick; check("run2_addr", 32'(addr), 2); check("run2_instr", 32'(instr), 'h101); check("run2_pc", 32'(pc), 1);
    tick; check("run3_addr", 32'(addr), 3); check("run3_instr", 32'(instr), 'h102); check("run3_pc", 32'(pc), 2);

    tick; tick;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_addr",  32'(addr),  5);
      check("stall_instr", 32'(instr), 'h104);
      check("stall_pc",    32'(pc),    4);
      check("stall_valid", 32'(valid), 1);
    end
    stall = 0;
    tick; check("unstall_addr", 32'(addr), 6); check("unstall_pc", 32'(pc), 5);

    tick;
    check("pre_jump_addr", 32'(addr), 7);
    jump = 1; target = 17'h1FFFF;
    tick; jump = 0;
    check("jump_addr", 32'(addr), 'h1FFFF); check("jump_valid", 32'(valid), 0);
    tick;
    check("wrap_addr", 32'(addr), 0); check("wrap_instr", 32'(instr), 'h200FF);
    check("wrap_pc", 32'(pc), 'h1FFFF); check("wrap_valid", 32'(valid), 1);

    repeat (9) tick;
    check("pre_halt_addr", 32'(addr), 9);
    halt = 1; tick; halt = 0;
    check("halt_halted", 32'(halted), 1); check("halt_valid", 32'(valid), 0); check("halt_addr", 32'(addr), 9);
    jump = 1; stall = 1; target = 17'h40; tick; jump = 0; stall = 0;
    check("halt_jump_ign", 32'(addr), 9);
    resume = 1; halt = 1; tick; halt = 0;
    check("halt_resume_both", 32'(halted), 1);
    tick; resume = 0;
    check("resume_halted", 32'(halted), 0); check("resume_valid", 32'(valid), 0); check("resume_addr", 32'(addr), 9);
    tick;
    check("resume_pc", 32'(pc), 9); check("resume_instr", 32'(instr), 'h109); check("resume_v", 32'(valid), 1);

    jump = 1; stall = 1; target = 17'h30; tick; jump = 0; stall = 0;
    check("jump_over_stall", 32'(addr), 'h30); check("jump_stall_valid", 32'(valid), 0);
    halt = 1; jump = 1; target = 17'h77; tick; halt = 0; jump = 0;
    check("halt_over_jump", 32'(addr), 'h30); check("halt_over_jump_h", 32'(halted), 1);
    resume = 1; tick; resume = 0; tick;

`ifndef RETURN_STACK_EN
    call = 1; target = 17'h50; tick; call = 0;
    check("call_as_jump", 32'(addr), 'h50); check("call_valid", 32'(valid), 0);
    ret = 1; tick; ret = 0;
    check("ret_ignored", 32'(addr), 'h51); check("ret_ign_pc", 32'(pc), 'h50);
    check("no_rs_err", 32'(rs_err), 0);
`else
    do_reset;
    ret = 1; tick; ret = 0;
    check("ret_empty_err", 32'(rs_err), 1); check("ret_empty_halt", 32'(halted), 1);
    check("ret_empty_addr", 32'(addr), 0);
    do_reset;
    check("rst_err_clr", 32'(rs_err), 0); check("rst_halt_clr", 32'(halted), 0);
    repeat (3) tick;
    call = 1; target = 17'h20; tick; call = 0;
    check("call_addr", 32'(addr), 'h20); check("call_valid", 32'(valid), 0);
    tick; check("call_first_pc", 32'(pc), 'h20);
    ret = 1; tick; ret = 0;
    check("ret_addr", 32'(addr), 3);
    tick;
    for (int i = 1; i <= 5; i++) begin
      call = 1; target = AW'(i * 'h100); tick;
    end
    call = 0;
    check("nest_err", 32'(rs_err), 1); check("nest_addr", 32'(addr), 'h500);
    ret = 1; repeat (4) tick;
    check("unwind_addr", 32'(addr), 'h100);
    tick; ret = 0;
    check("unwind_empty_halt", 32'(halted), 1);
`endif

    halt = 1; tick; halt = 0;
    check("pre_rst_halted", 32'(halted), 1);
    rst = 1; tick; rst = 0;
    check("midhalt_rst_addr",   32'(addr),   0);
    check("midhalt_rst_halted", 32'(halted), 0);
    check("midhalt_rst_err",    32'(rs_err), 0);
    check("midhalt_rst_valid",  32'(valid),  0);
    tick;

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
